uart_tx_fifo: RTL and testbench

Parametrised transmit FIFO between a byte producer and the UART transmitter in the buffered UART path. Queues up to 2^DEPTH_LOG2 words written with a one-cycle `dataReady` strobe and hands them to the transmitter one at a time. Each hand-off is a `txStart` pulse, paced by the transmitter's `txBusy`. Adds configurable width and depth, full/empty/level status, a sticky overflow flag, a synchronous flush, and a busy-acknowledge timeout.

---
 rtl/uart_tx_fifo.sv | 90 +++++++++
 tb/tb_uart_tx_fifo.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered transmit FIFO handing words to a UART transmitter one at a time
module uart_tx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH_LOG2  = 4,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  dataReady,
  input  logic                  txBusy,
  input  logic                  flush,
  input  logic                  clearOverflow,
  output logic                  txStart,
  output logic [DATA_WIDTH-1:0] txData,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;
  localparam logic [DEPTH_LOG2:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  state_t                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  tx_start_q, tx_start_d, ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  push, drop, pop;
  assign full     = level_q == DEPTH;
  assign empty    = level_q == '0;
  assign level    = level_q;
  assign txStart  = tx_start_q;
  assign txData   = tx_data_q;
  assign overflow = ovf_q;
  // FIFO bookkeeping plus transmit FSM next state; full is judged on the pre-edge level
  always_comb begin
    push       = dataReady && !full && !flush;
    drop       = dataReady && full && !flush;
    pop        = state_q == IDLE && !empty && !txBusy && !flush;
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_start_d = pop;
    tx_data_d  = pop ? mem[rd_ptr_q] : tx_data_q;
    wr_ptr_d   = flush ? '0 : push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d   = flush ? '0 : pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    level_d    = flush ? '0 : (push && !pop) ? level_q + (DEPTH_LOG2+1)'(1) :
                 (pop && !push) ? level_q - (DEPTH_LOG2+1)'(1) : level_q;
    ovf_d      = drop ? 1'b1 : clearOverflow ? 1'b0 : ovf_q;
    case (state_q)
      IDLE: if (pop) begin
        state_d = WAIT_ACK;
        cnt_d   = 8'd1;
      end
      WAIT_ACK: if (txBusy) begin
        state_d = WAIT_DONE;
        cnt_d   = '0;
      end else if (cnt_q == 8'(ACK_TIMEOUT)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt_q + 8'd1;
      WAIT_DONE: state_d = txBusy ? WAIT_DONE : IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Storage array; contents need no reset since level gates every read
  always_ff @(posedge clk) if (push) mem[wr_ptr_q] <= data;
  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      cnt_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      cnt_q      <= cnt_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ovf_q      <= ovf_d;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed vectors and corner sequences for uart_tx_fifo
module tb_uart_tx_fifo;
  logic clk = 0, rst = 1;
  logic dr = 0, busy_drv = 0, fl = 0, clr = 0;
  logic [7:0] din = 0;
  logic model_en = 0, model_busy = 0;
  int model_cnt = 0;
  logic busy;
  logic st0, full0, emp0, ovf0, st1, full1, emp1, ovf1;
  logic [7:0] txd0, txd1;
  logic [4:0] lvl0;
  logic [2:0] lvl1;
  logic [7:0] q0[$], q1[$];
  int checks = 0, failures = 0;
  typedef struct {
    logic dr; logic [7:0] d; logic busy; logic fl; logic clr;
    logic st; logic [7:0] txd; logic [4:0] lvl; logic ful; logic emp; logic ovf;
  } vec_t;
  vec_t tbl[13];
  always #5 clk = ~clk;
  assign busy = model_en ? model_busy : busy_drv;
  uart_tx_fifo u0 (.clk(clk), .rst(rst), .data(din), .dataReady(dr), .txBusy(busy),
    .flush(fl), .clearOverflow(clr), .txStart(st0), .txData(txd0), .full(full0),
    .empty(emp0), .level(lvl0), .overflow(ovf0));
  uart_tx_fifo #(.DEPTH_LOG2(2), .ACK_TIMEOUT(4)) u1 (.clk(clk), .rst(rst), .data(din),
    .dataReady(dr), .txBusy(busy), .flush(fl), .clearOverflow(clr), .txStart(st1),
    .txData(txd1), .full(full1), .empty(emp1), .level(lvl1), .overflow(ovf1));
  always @(posedge clk)
    if (!model_en) begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end else if (st0) begin
      model_busy <= 1'b1;
      model_cnt  <= 10;
    end else if (model_cnt > 1) model_cnt <= model_cnt - 1;
    else begin
      model_busy <= 1'b0;
      model_cnt  <= 0;
    end
  always @(posedge clk)
    if (!rst) begin
      if (st0) q0.push_back(txd0);
      if (st1) q1.push_back(txd1);
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic reset_dut();
    rst = 1; dr = 0; fl = 0; clr = 0; din = 0; busy_drv = 0; model_en = 0;
    tick();
    rst = 0;
    q0.delete();
    q1.delete();
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, " txStart"}, st0, 0);
    chk({tag, " txData"}, txd0, 0);
    chk({tag, " level"}, lvl0, 0);
    chk({tag, " empty"}, emp0, 1);
    chk({tag, " full"}, full0, 0);
    chk({tag, " overflow"}, ovf0, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{1, 8'h41, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0};
    tbl[1]  = '{0, 8'h00, 0, 0, 0, 1, 8'h41, 0, 0, 1, 0};
    tbl[2]  = '{0, 8'h00, 1, 0, 0, 0, 8'h41, 0, 0, 1, 0};
    tbl[3]  = '{1, 8'h42, 1, 0, 0, 0, 8'h41, 1, 0, 0, 0};
    tbl[4]  = '{1, 8'h43, 1, 0, 0, 0, 8'h41, 2, 0, 0, 0};
    tbl[5]  = '{1, 8'h44, 1, 0, 0, 0, 8'h41, 3, 0, 0, 0};
    tbl[6]  = '{1, 8'h45, 1, 0, 0, 0, 8'h41, 4, 0, 0, 0};
    tbl[7]  = '{1, 8'h46, 1, 0, 0, 0, 8'h41, 5, 0, 0, 0};
    tbl[8]  = '{1, 8'h66, 1, 1, 0, 0, 8'h41, 0, 0, 1, 0};
    tbl[9]  = '{0, 8'h00, 0, 0, 0, 0, 8'h41, 0, 0, 1, 0};
    tbl[10] = '{0, 8'h00, 0, 0, 0, 0, 8'h41, 0, 0, 1, 0};
    tbl[11] = '{1, 8'h47, 0, 1, 0, 0, 8'h41, 0, 0, 1, 0};
    tbl[12] = '{0, 8'h00, 0, 0, 1, 0, 8'h41, 0, 0, 1, 0};
    reset_dut();
    chk_reset("reset");
    for (int i = 0; i < 13; i++) begin
      dr = tbl[i].dr; din = tbl[i].d; busy_drv = tbl[i].busy; fl = tbl[i].fl; clr = tbl[i].clr;
      tick();
      chk($sformatf("vec%0d txStart", i), st0, tbl[i].st);
      chk($sformatf("vec%0d txData", i), txd0, tbl[i].txd);
      chk($sformatf("vec%0d level", i), lvl0, tbl[i].lvl);
      chk($sformatf("vec%0d full", i), full0, tbl[i].ful);
      chk($sformatf("vec%0d empty", i), emp0, tbl[i].emp);
      chk($sformatf("vec%0d overflow", i), ovf0, tbl[i].ovf);
    end
    dr = 0; fl = 0; clr = 0; busy_drv = 0;
    // back-to-back words against the transmitter model
    reset_dut();
    model_en = 1;
    for (int i = 0; i < 10; i++) begin
      dr = 1; din = 8'h41 + 8'(i);
      tick();
    end
    dr = 0;
    for (int c = 0; c < 400 && q0.size() < 10; c++) tick();
    chk("b2b count", q0.size(), 10);
    for (int i = 0; i < 10 && i < q0.size(); i++) chk($sformatf("b2b word%0d", i), q0[i], 8'h41 + 8'(i));
    chk("b2b overflow", ovf0, 0);
    // fill to full, drop one, drain, clear overflow
    reset_dut();
    busy_drv = 1;
    for (int i = 0; i < 16; i++) begin
      dr = 1; din = 8'h10 + 8'(i);
      tick();
    end
    dr = 0;
    chk("full level", lvl0, 16);
    chk("full flag", full0, 1);
    chk("full no ovf", ovf0, 0);
    dr = 1; din = 8'h99;
    tick();
    dr = 0;
    chk("drop overflow", ovf0, 1);
    chk("drop level", lvl0, 16);
    model_en = 1;
    for (int c = 0; c < 600 && q0.size() < 16; c++) tick();
    repeat (40) tick();
    chk("drain count", q0.size(), 16);
    for (int i = 0; i < 16 && i < q0.size(); i++) chk($sformatf("drain word%0d", i), q0[i], 8'h10 + 8'(i));
    chk("drain empty", emp0, 1);
    chk("ovf sticky", ovf0, 1);
    clr = 1;
    tick();
    clr = 0;
    chk("ovf cleared", ovf0, 0);
    // wrap-around on the depth-4 instance
    reset_dut();
    dr = 1; din = 8'hA0;
    tick();
    chk("wrap lvl1", lvl1, 1);
    din = 8'hA1;
    tick();
    chk("pushpop start", st1, 1);
    chk("pushpop level", lvl1, 1);
    dr = 0;
    for (int i = 2; i < 14; i++) begin
      for (int c = 0; c < 50 && full1; c++) tick();
      dr = 1; din = 8'hA0 + 8'(i);
      tick();
      dr = 0;
    end
    for (int c = 0; c < 200 && q1.size() < 14; c++) tick();
    chk("wrap count", q1.size(), 14);
    for (int i = 0; i < 14 && i < q1.size(); i++) chk($sformatf("wrap word%0d", i), q1[i], 8'hA0 + 8'(i));
    chk("wrap overflow", ovf1, 0);
    // ack timeout with txBusy stuck low on the depth-4 instance
    reset_dut();
    dr = 1; din = 8'h51;
    tick();
    chk("to first idle", st1, 0);
    din = 8'h52;
    tick();
    dr = 0;
    chk("to start0", st1, 1);
    chk("to data0", txd1, 8'h51);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("to wait%0d", i), st1, 0);
    end
    tick();
    chk("to start1", st1, 1);
    chk("to data1", txd1, 8'h52);
    chk("to level", lvl1, 0);
    repeat (8) tick();
    // asynchronous reset during WAIT_DONE
    reset_dut();
    dr = 1; din = 8'h77;
    tick();
    din = 8'h78;
    tick();
    busy_drv = 1; din = 8'h79;
    tick();
    dr = 0;
    tick();
    chk("pre-rst data", txd0, 8'h77);
    chk("pre-rst level", lvl0, 2);
    #2 rst = 1;
    #1 chk_reset("async rst");
    @(posedge clk);
    #1 rst = 0;
    busy_drv = 0;
    repeat (3) begin
      tick();
      chk("post-rst idle", st0, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
